ripple_cla8_block: RTL and testbench

Module `ripple_cla8` is an 8-bit sequential adder. It computes `A + B + c_in` using two 4-bit carry-lookahead (CLA) slices whose carry ripples from the low slice to the high slice across clock cycles. It is started by an enable level and signals completion with `ready`. It serves as the datapath add unit of the 8-bit computer and is controlled by the sequencer through `en`/`ready`.

---
 rtl/ripple_cla8_block.sv | 190 +++++++++++++++++++
 tb/tb_ripple_cla8_block.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_cla8_block.sv
`default_nettype none
// ============================================================================
// Module   : cla4 / ripple_cla8_block
// Purpose  : 8-bit sequential adder, {c_out, Output} = A + B + c_in.
//            Two 4-bit carry-lookahead slices. The carry out of the low
//            slice is registered and fed to the high slice one clock
//            later, so a result takes three edges from the first sampled
//            enable. A single enable level starts an operation, and
//            `ready` reports completion.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous, active-high reset
//            en     - operation enable (level)
//            A, B   - 8-bit operands
//            c_in   - carry into bit 0
//            Output - registered sum [7:0]
//            c_out  - registered carry out of bit 7
//            ready  - registered, high while Output/c_out hold the result
//                     of the current operation
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cla4: purely combinational 4-bit carry-lookahead slice.
// Every carry is a flat sum-of-products of g, p and c_i. No carry is
// derived from a lower carry inside the slice.
// ----------------------------------------------------------------------------
module cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c4_o,
   output logic       g_grp_o,
   output logic       p_grp_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = c_i;
   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_i);
   assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_i);

   assign g_grp_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
   assign p_grp_o = &p;

   assign s_o = p ^ c;

endmodule

// ----------------------------------------------------------------------------
// ripple_cla8_block: sequencer-controlled top level.
// ----------------------------------------------------------------------------
module ripple_cla8_block (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       c_in,
   output logic [7:0] Output,
   output logic       c_out,
   output logic       ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t     state_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic       cin_q;
   logic [3:0] lo_sum_q;   // low-nibble staging, never visible on Output
   logic       carry_q;    // c4 carried from the low slice to the high slice
   logic [7:0] sum_q;
   logic       cout_q;
   logic       ready_q;

   logic [3:0] lo_s;
   logic       lo_c4;
   logic       lo_gg;
   logic       lo_gp;
   logic [3:0] hi_s;
   logic       hi_c4;
   logic       hi_gg;
   logic       hi_gp;

   cla4 u_cla_lo (
      .a_i     (a_q[3:0]),
      .b_i     (b_q[3:0]),
      .c_i     (cin_q),
      .s_o     (lo_s),
      .c4_o    (lo_c4),
      .g_grp_o (lo_gg),
      .p_grp_o (lo_gp)
   );

   cla4 u_cla_hi (
      .a_i     (a_q[7:4]),
      .b_i     (b_q[7:4]),
      .c_i     (carry_q),
      .s_o     (hi_s),
      .c4_o    (hi_c4),
      .g_grp_o (hi_gg),
      .p_grp_o (hi_gp)
   );

   // The slices also produce group generate/propagate for use in a wider
   // lookahead tree. The carry between the two slices is registered, so
   // this adder does not consume those signals.
   logic grp_unused;
   assign grp_unused = lo_gg ^ lo_gp ^ hi_gg ^ hi_gp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         cin_q    <= 1'b0;
         lo_sum_q <= 4'h0;
         carry_q  <= 1'b0;
         sum_q    <= 8'h00;
         cout_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  a_q     <= A;
                  b_q     <= B;
                  cin_q   <= c_in;
                  state_q <= ST_LOW;
               end
            end
            ST_LOW: begin
               // Dropping en aborts the operation. The committed result
               // is left untouched.
               if (!en) begin
                  state_q <= ST_IDLE;
               end else begin
                  lo_sum_q <= lo_s;
                  carry_q  <= lo_c4;
                  state_q  <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (!en) begin
                  state_q <= ST_IDLE;
               end else begin
                  sum_q   <= {hi_s, lo_sum_q};
                  cout_q  <= hi_c4;
                  ready_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Hold the result until en drops. This forces one low
               // edge before the next operation can start.
               if (!en) begin
                  ready_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Output = sum_q;
   assign c_out  = cout_q;
   assign ready  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_cla8_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_cla8_block
// Purpose  : Self-checking bench for ripple_cla8_block. Expected sums are
//            pushed to a queue when an operation is started, then popped
//            and compared when ready rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_cla8_block;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] A;
   logic [7:0] B;
   logic       c_in;
   logic [7:0] Output;
   logic       c_out;
   logic       ready;

   int         errors;
   int         checks;
   logic [8:0] exp_q[$];
   logic [8:0] last_commit;   // model of the last committed {c_out, Output}

   ripple_cla8_block dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .A      (A),
      .B      (B),
      .c_in   (c_in),
      .Output (Output),
      .c_out  (c_out),
      .ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation from IDLE and checks ready at edges k, k+1 and k+2.
   // When scramble is set, the operand inputs are changed after edge k.
   // The result must still use the latched values. en is left high.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input bit scramble);
      logic [8:0] exp;
      logic [8:0] got;
      A = a; B = b; c_in = ci; en = 1'b1;
      exp_q.push_back(9'(a) + 9'(b) + 9'(ci));
      tick();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL op_ready_k: got %b want 0", ready);
      end
      if (scramble) begin
         A = ~a; B = b ^ 8'h5A; c_in = ~ci;
      end
      tick();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL op_ready_k1: got %b want 0", ready);
      end
      if (scramble) A = a ^ 8'hC3;
      tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL op_ready_k2: got %b want 1", ready);
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL op_scoreboard: queue empty, got %h want an entry", {c_out, Output});
      end else begin
         exp = exp_q.pop_front();
         got = {c_out, Output};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL op_sum a=%h b=%h ci=%b: got %h want %h", a, b, ci, got, exp);
         end
         last_commit = exp;
      end
   endtask

   task automatic rearm();
      en = 1'b0;
      tick();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL rearm_ready: got %b want 0", ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; A = 8'h00; B = 8'h00; c_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({c_out, Output, ready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_state: got c_out=%b Output=%h ready=%b want 0/00/0", c_out, Output, ready);
      end
      last_commit = 9'h000;
   endtask

   task automatic test_basic_add();
      run_op(8'd12, 8'd1, 1'b0, 1'b0);   rearm();
      run_op(8'h0F, 8'h01, 1'b0, 1'b0);  rearm();
      run_op(8'hFF, 8'h01, 1'b0, 1'b0);  rearm();
      run_op(8'd200, 8'd100, 1'b1, 1'b0); rearm();
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0);  rearm();
      run_op(8'h00, 8'h00, 1'b0, 1'b0);  rearm();
      run_op(8'h07, 8'h08, 1'b1, 1'b0);  rearm();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
         rearm();
      end
   endtask

   task automatic test_abort();
      // Abort while in LOW.
      A = 8'h33; B = 8'h44; c_in = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ready !== 1'b0 || {c_out, Output} !== last_commit) begin
            errors++;
            $display("FAIL abort_low: got ready=%b sum=%h want 0/%h", ready, {c_out, Output}, last_commit);
         end
      end
      // Abort while in HIGH.
      A = 8'h90; B = 8'h91; c_in = 1'b0; en = 1'b1;
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ready !== 1'b0 || {c_out, Output} !== last_commit) begin
            errors++;
            $display("FAIL abort_high: got ready=%b sum=%h want 0/%h", ready, {c_out, Output}, last_commit);
         end
      end
      // After an abort the block must be back in IDLE, ready for a new operation.
      run_op(8'h21, 8'h43, 1'b0, 1'b0);
      rearm();
   endtask

   task automatic test_isolation();
      run_op(8'hA5, 8'h3C, 1'b1, 1'b1);
      rearm();
      run_op(8'h18, 8'hF0, 1'b0, 1'b1);
      rearm();
   endtask

   task automatic test_back_to_back();
      run_op(8'h55, 8'hAA, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         A = 8'($urandom); B = 8'($urandom);
         tick();
         checks++;
         if (ready !== 1'b1 || {c_out, Output} !== last_commit) begin
            errors++;
            $display("FAIL hold_done: got ready=%b sum=%h want 1/%h", ready, {c_out, Output}, last_commit);
         end
      end
      rearm();
      run_op(8'h80, 8'h80, 1'b0, 1'b0);
      rearm();
   endtask

   task automatic test_reset_mid();
      // Reset during LOW.
      A = 8'h7E; B = 8'h01; c_in = 1'b1; en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      checks++;
      if ({c_out, Output, ready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_low: got c_out=%b Output=%h ready=%b want 0/00/0", c_out, Output, ready);
      end
      last_commit = 9'h000;
      run_op(8'h3A, 8'h0B, 1'b0, 1'b0);
      // Reset during DONE.
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      checks++;
      if ({c_out, Output, ready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_done: got c_out=%b Output=%h ready=%b want 0/00/0", c_out, Output, ready);
      end
      last_commit = 9'h000;
      run_op(8'hC8, 8'h64, 1'b1, 1'b0);
      rearm();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; en = 1'b0; A = 8'h00; B = 8'h00; c_in = 1'b0;
      last_commit = 9'h000;
      test_reset();
      test_basic_add();
      test_random();
      test_abort();
      test_isolation();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
